// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the multicycle MIPS control path.
//   - opcode constants (OP_*)
//   - 4-bit control FSM state encodings (state_e). These encodings are the
//     same in every build, including the ones without the ADDI states.
//   - ALUOp codes (ALUOP_*)
//   - decode_target(): the state entered after DECODE for a given opcode.
//     FETCH means the opcode is unsupported.
// Configuration macro: MC_ADDI_EN. When it is defined, opcode 001000 (addi)
// is supported. When it is not defined, addi is decoded as illegal.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // The state that follows DECODE. A result of FETCH marks an illegal opcode.
  function automatic state_e decode_target(input logic [5:0] op);
    state_e nxt;
    nxt = FETCH;
    case (op)
      OP_LW, OP_SW: nxt = MEMADR;
      OP_RTYPE:     nxt = EXEC;
      OP_BEQ:       nxt = BRANCH;
      OP_J:         nxt = JUMP;
`ifdef MC_ADDI_EN
      OP_ADDI:      nxt = ADDIEX;
`endif
      default:      nxt = FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath.
// The FSM steps through fetch, decode, execute, memory and write-back. The
// memory states FETCH, MEMRD and MEMWR wait for mem_ready.
// Ports:
//   clk, rst_n (asynchronous, active-low)
//   opcode      - instruction-register opcode, sampled in DECODE and MEMADR
//   zero        - ALU zero flag. The datapath uses it to gate PCwriteCond,
//                 so this FSM does not read it.
//   mem_ready   - the memory completes its access in this cycle
//   IRwrite, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, MemtoReg,
//   RegWrite, RegDst, ALUSrcA - datapath enables and selects
//   ALUSrcB, ALUOp, PCSource  - 2-bit datapath selects
//   illegal_op  - one-cycle pulse in DECODE for an unsupported opcode
//   state       - current state encoding (debug)
// Configuration macro: MC_ADDI_EN. It enables the ADDIEX and ADDIWB states.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRwrite,
  output logic             PCwrite,
  output logic             PCwriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state
);

  state_e state_q, state_d;
  state_e dec_next;

  // zero is consumed by the datapath only.
  logic unused_zero;
  assign unused_zero = zero;

  assign dec_next = decode_target(opcode);
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = dec_next;
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef MC_ADDI_EN
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    IRwrite     = 1'b0;
    PCwrite     = 1'b0;
    PCwriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALUOP_ADD;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Gating with rst_n keeps the instruction register and PC from being
        // written while reset is held.
        IRwrite = mem_ready & rst_n;
        PCwrite = mem_ready & rst_n;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = (dec_next == FETCH);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNC;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCwriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCwrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// A driver issues instructions with random memory wait counts and pushes the
// expected per-cycle state and control word into a queue. A monitor pops the
// queue on each falling edge and compares it with the DUT.
// Configuration macro: MC_ADDI_EN. When defined, addi is expected to execute.
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_JUMP = 9, S_ADDIEX = 10, S_ADDIWB = 11;
`ifdef MC_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IRwrite, PCwrite, PCwriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_control #(.OPC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .IRwrite(IRwrite), .PCwrite(PCwrite),
    .PCwriteCond(PCwriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Control word layout:
  // {IRwrite,PCwrite,PCwriteCond,IorD,MemRead,MemWrite,MemtoReg,RegWrite,
  //  RegDst,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegal_op}
  logic [16:0] act_ctrl;
  assign act_ctrl = {IRwrite, PCwrite, PCwriteCond, IorD, MemRead, MemWrite,
                     MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, illegal_op};

  int n_checks = 0;
  int n_pass   = 0;
  logic [20:0] exp_q[$];
  bit sb_en = 1'b0;

  // Expected control word for each state, taken from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic ill);
    logic irw, pcw, pcc, iord, mrd, mwr, m2r, rw, rd, sa, il;
    logic [1:0] sb, aop, pcs;
    {irw, pcw, pcc, iord, mrd, mwr, m2r, rw, rd, sa, il} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin sb = 2'b11; il = ill; end
      S_MEMADR: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_EXEC:   begin sa = 1; aop = 2'b10; end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_BRANCH: begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
      S_ADDIEX: begin sa = 1; sb = 2'b10; end
      S_ADDIWB: begin rw = 1; end
      default: ;
    endcase
    return {irw, pcw, pcc, iord, mrd, mwr, m2r, rw, rd, sa, sb, aop, pcs, il};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compares the DUT against the queue head on each falling edge.
  always @(negedge clk) begin
    if (sb_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("sb_state_ctrl", {11'd0, state, act_ctrl}, {11'd0, e});
      end
    end
  end

  // Drive one cycle: set inputs, record the expectation, advance past the edge.
  task automatic step(input int st, input logic mr, input logic ill);
    mem_ready = mr;
    zero      = 1'($urandom);
    exp_q.push_back({4'(st), exp_ctrl(st, mr, ill)});
    @(posedge clk); #1;
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) ||
           (ADDI_EN && op == 6'b001000);
  endfunction

  // Reference instruction model: the cycle-by-cycle state walk of one
  // instruction, given wait counts for fetch and the data access.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    opcode = op;
    for (int i = 0; i < wf; i++) step(S_FETCH, 1'b0, 1'b0);
    step(S_FETCH, 1'b1, 1'b0);
    step(S_DECODE, 1'($urandom), !op_legal(op));
    if (op_legal(op)) begin
      case (op)
        6'b100011: begin
          step(S_MEMADR, 1'($urandom), 1'b0);
          for (int i = 0; i < wm; i++) step(S_MEMRD, 1'b0, 1'b0);
          step(S_MEMRD, 1'b1, 1'b0);
          step(S_MEMWB, 1'($urandom), 1'b0);
        end
        6'b101011: begin
          step(S_MEMADR, 1'($urandom), 1'b0);
          for (int i = 0; i < wm; i++) step(S_MEMWR, 1'b0, 1'b0);
          step(S_MEMWR, 1'b1, 1'b0);
        end
        6'b000000: begin
          step(S_EXEC, 1'($urandom), 1'b0);
          step(S_ALUWB, 1'($urandom), 1'b0);
        end
        6'b000100: step(S_BRANCH, 1'($urandom), 1'b0);
        6'b000010: step(S_JUMP, 1'($urandom), 1'b0);
        default: begin
          step(S_ADDIEX, 1'($urandom), 1'b0);
          step(S_ADDIWB, 1'($urandom), 1'b0);
        end
      endcase
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    ops[6] = 6'b111111;

    // Reset state with mem_ready low: FETCH values, no write enables.
    rst_n = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(S_FETCH));
    chk("reset_ctrl", 32'(act_ctrl), 32'(exp_ctrl(S_FETCH, 1'b0, 1'b0)));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, followed by random instructions.
    sb_en = 1'b1;
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b000010, 2, 0);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    sb_en = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while MEMWR is stalled.
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; mem_ready = 1'b0;
    chk("memwr_reached", 32'(state), 32'(S_MEMWR));
    chk("memwr_we", 32'(MemWrite), 32'd1);
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'(S_FETCH));
    chk("async_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("async_rst_we", 32'({IRwrite, PCwrite, PCwriteCond, RegWrite}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch resumes after reset release.
    sb_en = 1'b1;
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 1, 2);
    sb_en = 1'b0;
    chk("sb_drained_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
